// File: rtl/grf_write_arbiter_if.sv
// Signal bundle between the pipeline/MDU sources, the GRF write port and the
// decode-stage hazard lookup of the GRF write arbiter.
interface grf_write_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;

    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic        mdu_ready;

    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_data;
    logic [31:0] grf_pc;
    logic        grf_src;

    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        pipe_stall;

    modport master (
        output wb_we, wb_addr, wb_data, wb_pc,
        output mdu_valid, mdu_addr, mdu_data, mdu_pc,
        output rd_addr1, rd_addr2,
        input  mdu_ready, grf_we, grf_addr, grf_data, grf_pc, grf_src, pipe_stall
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, wb_pc,
        input  mdu_valid, mdu_addr, mdu_data, mdu_pc,
        input  rd_addr1, rd_addr2,
        output mdu_ready, grf_we, grf_addr, grf_data, grf_pc, grf_src, pipe_stall
    );
endinterface

// File: rtl/grf_write_arbiter.sv
// Arbitrates the single GRF write port between pipeline writeback and a small
// FIFO of pending MDU results, with starvation and read-hazard forced drains.
module grf_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    grf_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_rdPtr;
    logic [PW-1:0]    r_wrPtr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;

    logic w_empty;
    logic w_ready;
    logic w_hit;
    logic w_force;
    logic w_grantWb;
    logic w_grantMdu;
    logic w_push;

    assign w_empty    = (r_count == '0);
    assign w_ready    = (r_count < CW'(DEPTH));
    assign w_force    = (r_starve == SW'(STARVE_MAX)) || w_hit;
    // A forced drain stalls upstream, so a pending WB request is not eligible.
    assign w_grantWb  = bus.wb_we && (bus.wb_addr != 5'd0) && !w_force;
    assign w_grantMdu = !w_empty && !w_grantWb;
    assign w_push     = bus.mdu_valid && w_ready && (bus.mdu_addr != 5'd0);

    assign bus.mdu_ready  = w_ready;
    assign bus.pipe_stall = w_force;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] &&
                (((bus.rd_addr1 != 5'd0) && (bus.rd_addr1 == r_addr[i])) ||
                 ((bus.rd_addr2 != 5'd0) && (bus.rd_addr2 == r_addr[i])))) begin
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        bus.grf_we   = 1'b0;
        bus.grf_addr = 5'd0;
        bus.grf_data = 32'd0;
        bus.grf_pc   = 32'd0;
        bus.grf_src  = 1'b0;
        if (w_grantWb) begin
            bus.grf_we   = 1'b1;
            bus.grf_addr = bus.wb_addr;
            bus.grf_data = bus.wb_data;
            bus.grf_pc   = bus.wb_pc;
        end else if (w_grantMdu) begin
            bus.grf_we   = r_live[r_rdPtr];
            bus.grf_addr = r_addr[r_rdPtr];
            bus.grf_data = r_data[r_rdPtr];
            bus.grf_pc   = r_pc[r_rdPtr];
            bus.grf_src  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wrPtr] <= bus.mdu_addr;
            r_data[r_wrPtr] <= bus.mdu_data;
            r_pc[r_wrPtr]   <= bus.mdu_pc;
        end
    end

    // Kill first, then push, so a result entering this cycle keeps its live bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live   <= '0;
            r_rdPtr  <= '0;
            r_wrPtr  <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_grantWb) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_addr[i] == bus.wb_addr) begin
                        r_live[i] <= 1'b0;
                    end
                end
            end
            if (w_push) begin
                r_live[r_wrPtr] <= 1'b1;
                r_wrPtr         <= r_wrPtr + PW'(1);
            end
            if (w_grantMdu) begin
                r_live[r_rdPtr] <= 1'b0;
                r_rdPtr         <= r_rdPtr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_grantMdu);
            if (w_empty || w_grantMdu) begin
                r_starve <= '0;
            end else if (w_grantWb && (r_starve != SW'(STARVE_MAX))) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end
endmodule
